// File: rtl/cmn_arb_lrg_matrix_pipe.sv
// cmn_arb_lrg_matrix_pipe: N:1 valid/ready arbiter with a least-recently-granted priority matrix
// and a registered output stage. Define CMN_ARB_LRG_LOCK_EN to hold a grant until a packet's last beat.
module cmn_arb_lrg_matrix_pipe #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PLD_WIDTH = 32,
  parameter int unsigned IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     v_vld_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
  input  logic [WIDTH-1:0]     v_last_s,
  output logic                 vld_m,
  input  logic                 rdy_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic [IDX_W-1:0]     idx_m
);

  // prio_q[i][j] = 1 means requestor j beats requestor i.
  logic [WIDTH-1:0]     prio_q [WIDTH];
  logic [WIDTH-1:0]     prio_d [WIDTH];

  logic                 vld_q, vld_d;
  logic [PLD_WIDTH-1:0] pld_q, pld_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [WIDTH-1:0]     req;
  logic [WIDTH-1:0]     gnt;
  logic                 acc;
  logic                 hs;
  logic                 upd;
  logic [PLD_WIDTH-1:0] pld_sel;
  logic [IDX_W-1:0]     idx_sel;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      req[i] = v_vld_s[i] & ~|(v_vld_s & prio_q[i]);
    end
  end

  assign acc     = ~vld_q | rdy_m;
  assign v_rdy_s = acc ? gnt : '0;
  assign hs      = acc & |gnt;

`ifdef CMN_ARB_LRG_LOCK_EN
  typedef enum logic {
    LK_OPEN,
    LK_HELD
  } lock_e;

  lock_e            lock_q, lock_d;
  logic [WIDTH-1:0] lock_oh_q, lock_oh_d;
  logic             last_hs;

  assign last_hs = |(gnt & v_last_s);
  // While held, the locked requestor is the only candidate, even if it drops valid.
  assign gnt     = (lock_q == LK_HELD) ? (v_vld_s & lock_oh_q) : req;
  assign upd     = hs & last_hs;

  always_comb begin
    lock_d    = lock_q;
    lock_oh_d = lock_oh_q;
    case (lock_q)
      LK_OPEN: begin
        if (hs && !last_hs) begin
          lock_d    = LK_HELD;
          lock_oh_d = gnt;
        end
      end
      LK_HELD: begin
        if (hs && last_hs) begin
          lock_d = LK_OPEN;
        end
      end
      default: lock_d = LK_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= LK_OPEN;
      lock_oh_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_oh_q <= lock_oh_d;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^v_last_s;
  assign gnt         = req;
  assign upd         = hs;
`endif

  always_comb begin
    pld_sel = '0;
    idx_sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (gnt[i]) begin
        pld_sel = v_pld_s[i];
        idx_sel = IDX_W'(i);
      end
    end
  end

  // Winner's row goes all-ones (everyone beats it); its column clears in every other row.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      prio_d[i] = prio_q[i];
    end
    if (upd) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        prio_d[i] = gnt[i] ? ~gnt : (prio_q[i] & ~gnt);
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    pld_d = pld_q;
    idx_d = idx_q;
    if (hs) begin
      vld_d = 1'b1;
      pld_d = pld_sel;
      idx_d = idx_sel;
    end else if (rdy_m) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      pld_q <= '0;
      idx_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        for (int unsigned j = 0; j < WIDTH; j++) begin
          prio_q[i][j] <= (j < i);
        end
      end
    end else begin
      vld_q <= vld_d;
      pld_q <= pld_d;
      idx_q <= idx_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        prio_q[i] <= prio_d[i];
      end
    end
  end

  assign vld_m = vld_q;
  assign pld_m = pld_q;
  assign idx_m = idx_q;

endmodule

// File: tb/tb_cmn_arb_lrg_matrix_pipe.sv
// Bench for cmn_arb_lrg_matrix_pipe: LRG order-list model checked every cycle plus directed literals.
module tb_cmn_arb_lrg_matrix_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  v_vld_s = '0;
  logic [3:0]  v_rdy_s;
  logic [31:0] pld [4];
  logic [3:0]  v_last_s = '1;
  logic        vld_m;
  logic        rdy_m = 1'b0;
  logic [31:0] pld_m;
  logic [1:0]  idx_m;

  int n_tests = 0;
  int n_fail  = 0;

  cmn_arb_lrg_matrix_pipe #(
    .WIDTH     (4),
    .PLD_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .v_vld_s  (v_vld_s),
    .v_rdy_s  (v_rdy_s),
    .v_pld_s  (pld),
    .v_last_s (v_last_s),
    .vld_m    (vld_m),
    .rdy_m    (rdy_m),
    .pld_m    (pld_m),
    .idx_m    (idx_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: priority is a list, front = highest; the winner moves to the back.
  int          ord [4] = '{0, 1, 2, 3};
  logic        m_vld = 1'b0;
  logic [31:0] m_pld = '0;
  int          m_idx = 0;
  logic        m_lk  = 1'b0;
  int          m_lki = 0;

  function automatic int mgrant();
    if (m_lk) return v_vld_s[m_lki] ? m_lki : -1;
    for (int k = 0; k < 4; k++) begin
      if (v_vld_s[ord[k]]) return ord[k];
    end
    return -1;
  endfunction

  function automatic void to_back(input int g);
    int p;
    p = 0;
    for (int k = 0; k < 4; k++) if (ord[k] == g) p = k;
    for (int k = p; k < 3; k++) ord[k] = ord[k+1];
    ord[3] = g;
  endfunction

  int   mu_g;
  logic mu_acc;
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 4; k++) ord[k] = k;
        m_vld = 1'b0; m_pld = '0; m_idx = 0; m_lk = 1'b0; m_lki = 0;
      end else begin
        mu_g   = mgrant();
        mu_acc = !m_vld || rdy_m;
        if (mu_acc && mu_g >= 0) begin
          m_vld = 1'b1;
          m_pld = pld[mu_g];
          m_idx = mu_g;
`ifdef CMN_ARB_LRG_LOCK_EN
          if (v_last_s[mu_g]) begin
            m_lk = 1'b0;
            to_back(mu_g);
          end else begin
            m_lk  = 1'b1;
            m_lki = mu_g;
          end
`else
          to_back(mu_g);
`endif
        end else if (rdy_m) begin
          m_vld = 1'b0;
        end
      end
    end
  end

  int          c_g;
  logic        c_acc;
  logic [31:0] c_rdy;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        c_g   = mgrant();
        c_acc = !m_vld || rdy_m;
        c_rdy = (c_acc && c_g >= 0) ? (32'd1 << c_g) : 32'd0;
        chk("model v_rdy_s", 32'(v_rdy_s), c_rdy);
        chk("model vld_m", 32'(vld_m), 32'(m_vld));
        chk("model pld_m", pld_m, m_pld);
        chk("model idx_m", 32'(idx_m), 32'(m_idx));
      end
    end
  end

  task automatic drv(input logic [3:0] v, input logic r, input logic [3:0] l);
    v_vld_s  = v;
    rdy_m    = r;
    v_last_s = l;
  endtask

  task automatic set_pld(input logic [31:0] base);
    for (int i = 0; i < 4; i++) pld[i] = base + 32'(i);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Called at posedge+1; asserts reset mid-cycle and releases it off-edge one cycle later.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    drv(4'b0000, 1'b0, 4'b1111);
    #1;
    chk("reset vld_m", 32'(vld_m), 32'd0);
    chk("reset pld_m", pld_m, 32'd0);
    chk("reset idx_m", 32'(idx_m), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int e_rr [5] = '{0, 1, 2, 3, 0};
`ifdef CMN_ARB_LRG_LOCK_EN
  int e_pk [5] = '{1, 1, 1, 2, 3};
`else
  int e_pk [5] = '{1, 2, 3, 0, 1};
`endif

  logic [3:0] sw_v [16] = '{4'b1010, 4'b0110, 4'b0000, 4'b1111, 4'b0001, 4'b1001, 4'b1111, 4'b0011,
                            4'b1100, 4'b0000, 4'b1111, 4'b0101, 4'b1110, 4'b1111, 4'b0010, 4'b1000};
  logic       sw_r [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] sw_l [16] = '{4'b1111, 4'b0101, 4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111, 4'b1111,
                            4'b1101, 4'b1111, 4'b1111, 4'b1010, 4'b1111, 4'b1111, 4'b1111, 4'b1111};

  initial begin
    set_pld(32'hA000_0000);
    @(posedge clk);
    #1;

    // Round robin from reset, all valid
    do_reset();
    set_pld(32'hA000_0000);
    drv(4'b1111, 1'b1, 4'b1111);
    smp();
    chk("rr first rdy", 32'(v_rdy_s), 32'h1);
    chk("rr vld_m cycle0", 32'(vld_m), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      smp();
      chk("rr idx_m", 32'(idx_m), 32'(e_rr[k]));
      chk("rr vld_m", 32'(vld_m), 32'd1);
    end
    cyc();

    // Single requestor 2, then 0 and 2
    do_reset();
    set_pld(32'hC0DE_0000);
    drv(4'b0100, 1'b1, 4'b1111);
    smp();
    chk("solo rdy", 32'(v_rdy_s), 32'h4);
    cyc();
    drv(4'b0101, 1'b1, 4'b1111);
    smp();
    chk("solo idx_m", 32'(idx_m), 32'd2);
    chk("solo pld_m", pld_m, 32'hC0DE_0002);
    chk("after2 rdy", 32'(v_rdy_s), 32'h1);
    cyc();

    // Downstream stall with all valid
    do_reset();
    set_pld(32'h1000_0000);
    drv(4'b1111, 1'b1, 4'b1111);
    smp(); cyc(); smp(); cyc();
    drv(4'b1111, 1'b0, 4'b1111);
    for (int s = 0; s < 5; s++) begin
      smp();
      chk("stall rdy", 32'(v_rdy_s), 32'h0);
      chk("stall idx_m", 32'(idx_m), 32'd1);
      chk("stall pld_m", pld_m, 32'h1000_0001);
      chk("stall vld_m", 32'(vld_m), 32'd1);
      if (s == 0) set_pld(32'h2000_0000);
      cyc();
    end
    drv(4'b1111, 1'b1, 4'b1111);
    smp();
    chk("unstall rdy", 32'(v_rdy_s), 32'h4);
    cyc();
    smp();
    chk("unstall idx_m", 32'(idx_m), 32'd2);
    chk("unstall pld_m", pld_m, 32'h2000_0002);
    cyc();

    // Reset mid-stream after grants 0,1
    do_reset();
    set_pld(32'h3000_0000);
    drv(4'b1111, 1'b1, 4'b1111);
    smp(); cyc(); smp(); cyc();
    do_reset();
    drv(4'b1111, 1'b1, 4'b1111);
    smp();
    chk("post-reset rdy", 32'(v_rdy_s), 32'h1);
    cyc();

    // Three-beat packet from requestor 1 amid competition
    do_reset();
    set_pld(32'h4000_0000);
    drv(4'b0001, 1'b1, 4'b1111);
    smp(); cyc();
    for (int p = 0; p < 6; p++) begin
      drv(4'b1111, 1'b1, (p >= 2) ? 4'b1111 : 4'b1101);
      smp();
      if (p >= 1) chk("pkt idx_m", 32'(idx_m), 32'(e_pk[p-1]));
      cyc();
    end

`ifdef CMN_ARB_LRG_LOCK_EN
    // Locked requestor drops valid: others must stall
    do_reset();
    drv(4'b0001, 1'b1, 4'b1111);
    smp(); cyc();
    drv(4'b1111, 1'b1, 4'b1101);
    smp(); cyc();
    drv(4'b1101, 1'b1, 4'b1101);
    smp();
    chk("gap rdy", 32'(v_rdy_s), 32'h0);
    cyc();
    drv(4'b1111, 1'b1, 4'b1111);
    smp();
    chk("gap resume rdy", 32'(v_rdy_s), 32'h2);
    cyc();
    smp();
    chk("gap release rdy", 32'(v_rdy_s), 32'h4);
    cyc();
`endif

    // Mixed valid/ready sweep, checked by the model
    for (int t = 0; t < 16; t++) begin
      if (t == 6) set_pld(32'h5A5A_0000);
      drv(sw_v[t], sw_r[t], sw_l[t]);
      smp();
      cyc();
    end
    drv(4'b0000, 1'b1, 4'b1111);
    smp(); cyc(); smp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
